// File: rtl/rv32i_fetch_unit.sv
// RV32I instruction fetch: PC register, combinational imem lookup and a
// 2-entry in-order {pc, instr} queue feeding decode, with redirect flush.
module rv32i_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_instr,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_pc,
  output logic [31:0] out_instr,
  output logic [1:0]  fetch_count
);

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } entry_t;

  logic [31:0]      pc_q, pc_d;
  logic [1:0]       count_q, count_d;
  entry_t [1:0]     ent_q, ent_d;
  logic             pop, fetch, wr_idx;

  assign imem_addr   = pc_q;
  assign fetch_count = count_q;
  assign out_valid   = (count_q != 2'd0) && !redirect_valid;
  assign out_pc      = ent_q[0].pc;
  assign out_instr   = ent_q[0].instr;
  assign pop         = out_valid && out_ready;
  assign fetch       = !redirect_valid && ((count_q != 2'd2) || pop);

  // Slot 0 is always the head; a full queue can only fetch while popping,
  // so the new entry then lands in slot 1 after the shift.
  assign wr_idx = (count_q == 2'd2) || ((count_q == 2'd1) && !pop);

  always_comb begin
    pc_d    = pc_q;
    count_d = count_q;
    ent_d   = ent_q;
    if (redirect_valid) begin
      pc_d    = {redirect_pc[31:2], 2'b00};
      count_d = 2'd0;
    end else begin
      if (pop)
        ent_d[0] = ent_q[1];
      if (fetch) begin
        pc_d          = pc_q + 32'd4;
        ent_d[wr_idx] = '{pc: pc_q, instr: imem_instr};
      end
      count_d = count_q + {1'b0, fetch} - {1'b0, pop};
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pc_q    <= RESET_PC;
      count_q <= 2'd0;
    end else begin
      pc_q    <= pc_d;
      count_q <= count_d;
    end
    ent_q <= ent_d;
  end

endmodule

// File: tb/tb_rv32i_fetch_unit.sv
// Scoreboard bench for rv32i_fetch_unit: expected instruction streams are
// queued on each reset/redirect and popped by a monitor on every handshake.
module tb_rv32i_fetch_unit;

  logic        clk;
  logic        rst_n, redirect_valid, out_ready;
  logic [31:0] redirect_pc, imem_addr, imem_instr, out_pc, out_instr;
  logic        out_valid;
  logic [1:0]  fetch_count;

  logic        rst1_n;
  logic [31:0] imem_addr1, imem_instr1, out_pc1, out_instr1;
  logic        out_valid1;
  logic [1:0]  fetch_count1;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] gen_pc;
  int          total = 0;
  int          bad = 0;
  logic        prev_ok = 1'b0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a < 32'd16) return ({30'd0, a[3:2]} + 32'd1) * 32'h11;
    return (a * 32'h9E37_79B1) ^ 32'h5EED_0000;
  endfunction

  assign imem_instr  = mem_word(imem_addr);
  assign imem_instr1 = mem_word(imem_addr1);

  rv32i_fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .rst_n(rst_n), .imem_addr(imem_addr), .imem_instr(imem_instr),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
    .out_instr(out_instr), .fetch_count(fetch_count));

  rv32i_fetch_unit #(.RESET_PC(32'hFFFF_FFF8)) dut_wrap (
    .clk(clk), .rst_n(rst1_n), .imem_addr(imem_addr1), .imem_instr(imem_instr1),
    .redirect_valid(1'b0), .redirect_pc(32'h0),
    .out_valid(out_valid1), .out_ready(1'b1), .out_pc(out_pc1),
    .out_instr(out_instr1), .fetch_count(fetch_count1));

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  task automatic refill();
    while (exp_q.size() < 8) begin
      exp_q.push_back('{pc: gen_pc, instr: mem_word(gen_pc)});
      gen_pc = gen_pc + 32'd4;
    end
  endtask

  task automatic start_stream(input logic [31:0] pc);
    exp_q.delete();
    gen_pc = pc;
    refill();
  endtask

  // A cycle that neither resets nor redirects always leaves at least one
  // entry queued, so out_valid is fully determined by the previous cycle.
  always @(negedge clk) begin
    if (rst_n) begin
      check("valid_rule", {31'd0, out_valid}, {31'd0, prev_ok && !redirect_valid});
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("sb_underflow", 32'd1, 32'd0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          check("sb_pc", out_pc, e.pc);
          check("sb_instr", out_instr, e.instr);
          refill();
        end
      end
    end
    prev_ok <= rst_n && !redirect_valid;
  end

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; rst1_n = 1'b0;
    redirect_valid = 1'b0; redirect_pc = 32'h0; out_ready = 1'b1;
    start_stream(32'h0);
    nxt(); nxt();
    rst_n = 1'b1; rst1_n = 1'b1;
    @(negedge clk);
    check("rst_valid", {31'd0, out_valid}, 32'd0);
    check("rst_count", {30'd0, fetch_count}, 32'd0);
    check("rst_addr", imem_addr, 32'h0);
    check("wrap_rst_addr", imem_addr1, 32'hFFFF_FFF8);
    for (int i = 0; i < 4; i++) begin
      nxt();
      @(negedge clk);
      check("t1_valid", {31'd0, out_valid}, 32'd1);
      check("t1_pc", out_pc, 32'(4 * i));
      check("t1_instr", out_instr, 32'(32'h11 * (i + 1)));
      check("wrap_valid", {31'd0, out_valid1}, 32'd1);
      check("wrap_pc", out_pc1, 32'hFFFF_FFF8 + 32'(4 * i));
    end

    // stall decode after reset: queue fills, PC parks at 0x8
    nxt();
    rst_n = 1'b0; out_ready = 1'b0;
    start_stream(32'h0);
    nxt();
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) nxt();
    @(negedge clk);
    check("t2_count", {30'd0, fetch_count}, 32'd2);
    check("t2_addr", imem_addr, 32'h8);
    nxt();
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("t2_valid", {31'd0, out_valid}, 32'd1);
      check("t2_pc", out_pc, 32'(4 * i));
      nxt();
    end

    // redirect while full
    out_ready = 1'b0;
    nxt(); nxt(); nxt();
    @(negedge clk);
    check("t3_full", {30'd0, fetch_count}, 32'd2);
    nxt();
    redirect_valid = 1'b1; redirect_pc = 32'h100;
    start_stream(32'h100);
    @(negedge clk);
    check("t3_valid_n", {31'd0, out_valid}, 32'd0);
    nxt();
    redirect_valid = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    check("t3_valid_n1", {31'd0, out_valid}, 32'd0);
    check("t3_addr_n1", imem_addr, 32'h100);
    for (int i = 0; i < 2; i++) begin
      nxt();
      @(negedge clk);
      check("t3_valid", {31'd0, out_valid}, 32'd1);
      check("t3_pc", out_pc, 32'h100 + 32'(4 * i));
    end

    // misaligned redirect target
    nxt();
    redirect_valid = 1'b1; redirect_pc = 32'h203;
    start_stream(32'h200);
    nxt();
    redirect_valid = 1'b0;
    nxt();
    @(negedge clk);
    check("t4_pc", out_pc, 32'h200);

    // reset wins over a simultaneous redirect on a full queue
    nxt();
    out_ready = 1'b0;
    nxt(); nxt(); nxt();
    rst_n = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'h400;
    start_stream(32'h0);
    nxt();
    rst_n = 1'b1; redirect_valid = 1'b0; out_ready = 1'b1;
    @(negedge clk);
    check("t5_count", {30'd0, fetch_count}, 32'd0);
    check("t5_addr", imem_addr, 32'h0);
    check("t5_valid", {31'd0, out_valid}, 32'd0);

    for (int i = 0; i < 3000; i++) begin
      nxt();
      rst_n          = ($urandom_range(0, 127) != 0);
      redirect_valid = ($urandom_range(0, 15) == 0);
      redirect_pc    = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFF0 | 32'($urandom_range(0, 15))
                                                   : $urandom;
      out_ready      = ($urandom_range(0, 3) != 0);
      if (!rst_n) start_stream(32'h0);
      else if (redirect_valid) start_stream({redirect_pc[31:2], 2'b00});
    end
    nxt();
    rst_n = 1'b1; redirect_valid = 1'b0; out_ready = 1'b1;
    for (int i = 0; i < 6; i++) nxt();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rv32i_fetch_unit.md
RV32I_FETCH_UNIT -- requirements
Module: rv32i_fetch_unit

Interface
REQ-001 Parameter: RESET_PC, 32'h0000_0000, byte address fetched first after reset.
REQ-002 Port: clk  input  1  sole clock, all state updates on rising edge.
REQ-003 Port: rst_n  input  1  synchronous, active-low reset, sampled on rising clk edge.
REQ-004 Port: imem_addr  output  32  byte address to instruction memory, equal to internal PC.
REQ-005 Port: imem_instr  input  32  combinational instruction-memory read data for imem_addr.
REQ-006 Port: redirect_valid  input  1  branch/jump/trap redirect request.
REQ-007 Port: redirect_pc  input  32  redirect target byte address.
REQ-008 Port: out_valid  output  1  queue head holds a valid fetched instruction.
REQ-009 Port: out_ready  input  1  decode stage accepts head this cycle.
REQ-010 Port: out_pc  output  32  byte address of head instruction.
REQ-011 Port: out_instr  output  32  head instruction word.
REQ-012 Port: fetch_count  output  2  current queue occupancy, 0..2.

Function
REQ-013 The block SHALL hold a 32-bit PC register and drive imem_addr = PC combinationally.
REQ-014 The block SHALL contain a 2-entry in-order queue of {pc, instr} pairs; fetch_count = occupancy.
REQ-015 pop SHALL be out_valid && out_ready; out_valid = (fetch_count != 0) && !redirect_valid.
REQ-016 out_pc/out_instr SHALL show the head entry; values when out_valid=0 are don't-care.
REQ-017 fetch SHALL occur in a cycle iff !redirect_valid && (fetch_count < 2 || pop).
REQ-018 On fetch: enqueue {PC, imem_instr} at the tail and PC <= PC + 4, modulo 2^32 (0xFFFF_FFFC + 4 = 0).
REQ-019 No fetch: PC and imem_addr SHALL hold their value.
REQ-020 Simultaneous fetch and pop SHALL keep fetch_count unchanged and advance head; pop alone decrements; fetch alone increments.
REQ-021 redirect_valid SHALL have priority over fetch and pop: queue flushed (fetch_count <= 0), PC <= {redirect_pc[31:2], 2'b00}, no enqueue, no pop.
REQ-022 redirect_pc[1:0] SHALL be discarded silently (no error reported).
REQ-023 Redirect asserted in cycle N: imem_addr = target in N+1, entry enqueued end of N+1, out_valid earliest in N+2.
REQ-024 Back-to-back redirects SHALL each take effect; the last one in a run determines PC.
REQ-025 Throughput SHALL be one instruction per cycle with out_ready held high and no redirects.
REQ-026 Instructions SHALL leave in fetch order; none duplicated or dropped except by redirect flush.

Reset
REQ-027 While rst_n=0 at a rising edge: PC <= RESET_PC, fetch_count <= 0, so out_valid=0 and imem_addr=RESET_PC after that edge.
REQ-028 Reset SHALL override redirect, fetch and pop in the same cycle.
REQ-029 First cycle with rst_n=1 SHALL fetch RESET_PC; out_valid first asserts one cycle later.
REQ-030 Reset asserted mid-operation SHALL discard all queued entries; no pre-reset instruction appears afterwards.

Verification
REQ-031 Reset, mem[0..3]=0x11,0x22,0x33,0x44, out_ready=1 -> out_valid=0 cycle 0; then out_pc 0x0,0x4,0x8,0xC with instrs 0x11..0x44 on consecutive cycles.
REQ-032 out_ready=0 for 5 cycles after reset -> fetch_count reaches 2, imem_addr holds 0x8; out_ready=1 -> out_pc 0x0,0x4,0x8 consecutively, none lost.
REQ-033 Queue full, redirect_valid=1 with redirect_pc=0x100 for one cycle -> out_valid=0 that cycle and next; then out_pc=0x100, 0x104; no old entries reappear.
REQ-034 redirect_pc=0x203 -> next out_pc=0x200.
REQ-035 RESET_PC=0xFFFF_FFF8, out_ready=1 -> out_pc 0xFFFF_FFF8, 0xFFFF_FFFC, 0x0000_0000.
REQ-036 rst_n=0 for one cycle while fetch_count=2 and redirect_valid=1 -> next cycle fetch_count=0, imem_addr=RESET_PC, out_valid=0.
